// File: rtl/multitone_gen_pkg.sv
// multitone_gen_pkg
// Shared types and helpers for the multitone stimulus generator:
//   PI            - circle constant used for phase-to-angle conversion
//   gen_state_e   - sequencing states of the generator
//   gen_mode_e    - continuous / burst run mode
//   phase_sin()   - sine of a phase given as a fraction of a full turn
package multitone_gen_pkg;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } gen_state_e;

    typedef enum logic {
        MODE_CONT  = 1'b0,
        MODE_BURST = 1'b1
    } gen_mode_e;

    function automatic real phase_sin(input real frac);
        return $sin(2.0 * PI * frac);
    endfunction

endpackage

// File: rtl/multitone_gen_tone_nco.sv
// multitone_gen_tone_nco
// One tone of the generator: config registers plus phase accumulator.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   cfg_wr_i        - write strobe for this tone (already index-decoded)
//   cfg_en_i/ftw_i/phase_i/amp_i - config values captured on cfg_wr_i
//   active_i        - generator is outside IDLE: accumulate, else hold start phase
//   tone_o          - amp * sin(phase_acc), 0.0 when the tone is disabled
module multitone_gen_tone_nco
    import multitone_gen_pkg::*;
#(
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr_i,
    input  logic               cfg_en_i,
    input  logic [PHASE_W-1:0] cfg_ftw_i,
    input  logic [PHASE_W-1:0] cfg_phase_i,
    input  real                cfg_amp_i,
    input  logic               active_i,
    output real                tone_o
);

    logic               en_q;
    logic [PHASE_W-1:0] ftw_q;
    logic [PHASE_W-1:0] start_phase_q;
    logic [PHASE_W-1:0] phase_acc_q;
    real                amp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            ftw_q         <= '0;
            start_phase_q <= '0;
            phase_acc_q   <= '0;
            amp_q         <= 0.0;
        end else begin
            // Accumulation uses the pre-write ftw, so a rewrite only changes
            // the slope from the next step on and never jumps the phase.
            if (active_i) begin
                phase_acc_q <= phase_acc_q + ftw_q;
            end else begin
                phase_acc_q <= start_phase_q;
            end
            if (cfg_wr_i) begin
                en_q          <= cfg_en_i;
                ftw_q         <= cfg_ftw_i;
                start_phase_q <= cfg_phase_i;
                amp_q         <= cfg_amp_i;
            end
        end
    end

    always_comb begin
        tone_o = 0.0;
        if (en_q) begin
            tone_o = amp_q * phase_sin(real'(phase_acc_q) / (2.0 ** PHASE_W));
        end
    end

endmodule

// File: rtl/multitone_gen.sv
// multitone_gen
// Sum of NUM_TONES programmable sinusoids with start/stop sequencing,
// continuous/burst modes and a linear gain ramp on start and stop.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   cfg_we, cfg_idx      - tone config write strobe and tone index
//   cfg_en/ftw/phase/amp - tone enable, tuning word, start phase, amplitude
//   mode, burst_len      - 0 continuous / 1 burst, RUN length in burst mode
//   start, stop          - level-sampled sequencing requests (stop wins)
//   busy, done           - not idle, one-cycle pulse on return to idle
//   out_valid, sin_out   - registered tone sum, SIN_DC offset, gain applied
module multitone_gen
    import multitone_gen_pkg::*;
#(
    parameter int  NUM_TONES  = 4,
    parameter int  PHASE_W    = 24,
    parameter int  BURST_W    = 16,
    parameter int  RAMP_STEPS = 16,
    parameter real SIN_DC     = 0.5,
    localparam int IDX_W      = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  real                cfg_amp,
    input  logic               mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    output real                sin_out
);

    localparam int K_W = (RAMP_STEPS > 0) ? $clog2(RAMP_STEPS + 1) : 1;
    localparam logic [K_W-1:0] K_MAX = K_W'(RAMP_STEPS);

    gen_state_e         state_q;
    logic [K_W-1:0]     k_q;
    logic [BURST_W-1:0] cnt_q;
    logic               done_q;
    logic               valid_q;
    real                sin_q;

    logic active;
    real  tone_val [NUM_TONES];
    real  tone_sum;
    real  gain;

    assign active = (state_q != ST_IDLE);

    for (genvar g = 0; g < NUM_TONES; g++) begin : g_tone
        multitone_gen_tone_nco #(.PHASE_W(PHASE_W)) u_nco (
            .clk         (clk),
            .rst_n       (rst_n),
            .cfg_wr_i    (cfg_we && (cfg_idx == IDX_W'(g))),
            .cfg_en_i    (cfg_en),
            .cfg_ftw_i   (cfg_ftw),
            .cfg_phase_i (cfg_phase),
            .cfg_amp_i   (cfg_amp),
            .active_i    (active),
            .tone_o      (tone_val[g])
        );
    end

    always_comb begin
        tone_sum = 0.0;
        for (int i = 0; i < NUM_TONES; i++) begin
            tone_sum = tone_sum + tone_val[i];
        end
        gain = (RAMP_STEPS == 0) ? 1.0 : real'(k_q) / real'(RAMP_STEPS);
    end

    // Entering either ramp state already steps k, so every ramp cycle
    // carries a new gain level and there is no repeated sample at a turn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            sin_q   <= SIN_DC;
        end else begin
            done_q  <= 1'b0;
            valid_q <= active;
            sin_q   <= active ? (SIN_DC + gain * tone_sum) : SIN_DC;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        cnt_q <= burst_len;
                        if (RAMP_STEPS == 0) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_RAMP_UP;
                            k_q     <= K_W'(1);
                        end
                    end
                end
                ST_RAMP_UP: begin
                    if (stop) begin
                        state_q <= ST_RAMP_DOWN;
                        k_q     <= k_q - K_W'(1);
                    end else if (k_q == K_MAX) begin
                        state_q <= ST_RUN;
                        cnt_q   <= burst_len;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                ST_RUN: begin
                    // burst_len of 0 or 1 both give a single RUN cycle
                    if (stop || ((gen_mode_e'(mode) == MODE_BURST) && (cnt_q <= BURST_W'(1)))) begin
                        if (RAMP_STEPS == 0) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RAMP_DOWN;
                            k_q     <= k_q - K_W'(1);
                        end
                    end else if (gen_mode_e'(mode) == MODE_BURST) begin
                        cnt_q <= cnt_q - BURST_W'(1);
                    end
                end
                ST_RAMP_DOWN: begin
                    if (k_q == '0) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_q - K_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = active;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign sin_out   = sin_q;

endmodule

// File: tb/tb_multitone_gen.sv
module tb_multitone_gen;

    localparam int  NT = 3;
    localparam int  PW = 8;
    localparam int  BW = 8;
    localparam int  RS = 4;
    localparam real DC = 0.5;
    localparam real TWO_PI = 6.283185307179586477;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic          cfg_en = 1'b0;
    logic [PW-1:0] cfg_ftw = '0;
    logic [PW-1:0] cfg_phase = '0;
    real           cfg_amp = 0.0;
    logic          mode = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy, done, out_valid;
    real           sin_out;

    multitone_gen #(
        .NUM_TONES(NT), .PHASE_W(PW), .BURST_W(BW), .RAMP_STEPS(RS), .SIN_DC(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_en(cfg_en), .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
        .mode(mode), .burst_len(burst_len), .start(start), .stop(stop),
        .busy(busy), .done(done), .out_valid(out_valid), .sin_out(sin_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit  v;
        bit  b;
        bit  d;
        real s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: generator is "running" with a gain level m_k out of RS
    // and a direction of travel (+1 rising, 0 holding, -1 falling).
    bit  m_run;
    int  m_k, m_dir, m_left;
    bit  m_en[NT];
    int  m_ftw[NT], m_sp[NT], m_ph[NT];
    real m_amp[NT];

    function automatic void model_step();
        exp_t e;
        real  sum;
        e.v = 0; e.b = 0; e.d = 0; e.s = DC;
        if (!rst_n) begin
            m_run = 0; m_k = 0; m_dir = 0; m_left = 0;
            for (int i = 0; i < NT; i++) begin
                m_en[i] = 0; m_ftw[i] = 0; m_sp[i] = 0; m_ph[i] = 0; m_amp[i] = 0.0;
            end
        end else begin
            sum = 0.0;
            for (int i = 0; i < NT; i++)
                if (m_en[i]) sum += m_amp[i] * $sin(TWO_PI * real'(m_ph[i]) / 256.0);
            e.v = m_run;
            e.s = m_run ? DC + (real'(m_k) / real'(RS)) * sum : DC;
            for (int i = 0; i < NT; i++)
                m_ph[i] = m_run ? (m_ph[i] + m_ftw[i]) % 256 : m_sp[i];
            if (!m_run) begin
                if (start && !stop) begin
                    m_run = 1; m_k = 1; m_dir = 1; m_left = int'(burst_len);
                end
            end else if (m_dir == 1) begin
                if (stop) begin m_dir = -1; m_k--; end
                else if (m_k == RS) begin m_dir = 0; m_left = int'(burst_len); end
                else m_k++;
            end else if (m_dir == 0) begin
                if (stop || (mode && m_left <= 1)) begin m_dir = -1; m_k--; end
                else if (mode) m_left--;
            end else begin
                if (m_k == 0) begin m_run = 0; e.d = 1; end
                else m_k--;
            end
            e.b = m_run;
            if (cfg_we && int'(cfg_idx) < NT) begin
                m_en[cfg_idx]  = cfg_en;
                m_ftw[cfg_idx] = int'(cfg_ftw);
                m_sp[cfg_idx]  = int'(cfg_phase);
                m_amp[cfg_idx] = cfg_amp;
            end
        end
        q.push_back(e);
    endfunction

    // Monitor: pops one expectation per clock and compares the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 4;
                if (out_valid !== e.v) begin
                    errors++; $display("FAIL out_valid t=%0t got %0b want %0b", $time, out_valid, e.v);
                end
                if (busy !== e.b) begin
                    errors++; $display("FAIL busy t=%0t got %0b want %0b", $time, busy, e.b);
                end
                if (done !== e.d) begin
                    errors++; $display("FAIL done t=%0t got %0b want %0b", $time, done, e.d);
                end
                if ((sin_out - e.s) > 1e-9 || (e.s - sin_out) > 1e-9) begin
                    errors++; $display("FAIL sin_out t=%0t got %f want %f", $time, sin_out, e.s);
                end
            end
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
        cfg_we = 0; start = 0; stop = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input int idx, input bit en, input int ftw, input int ph, input real amp);
        cfg_idx = 2'(idx); cfg_en = en; cfg_ftw = PW'(ftw); cfg_phase = PW'(ph); cfg_amp = amp;
        cfg_we = 1;
        tick();
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin tick(); n++; end
        checks++;
        if (busy) begin
            errors++; $display("FAIL idle_timeout got busy=%0b want 0 after %0d cycles", busy, n);
        end
        ticks(2);
    endtask

    initial begin
        rst_n = 0;
        ticks(3);
        rst_n = 1;
        ticks(2);

        // single tone, continuous
        cfg(0, 1, 16, 0, 0.5);
        start = 1; tick();
        ticks(40);
        stop = 1; tick();
        wait_idle(20);

        // two tones
        cfg(0, 1, 16, 0, 0.25);
        cfg(1, 1, 32, 64, 0.25);
        start = 1; tick();
        ticks(30);
        stop = 1; tick();
        wait_idle(20);

        // ramp, stop after 10 cycles
        start = 1; tick();
        ticks(9);
        stop = 1; tick();
        wait_idle(20);

        // burst of 5, then burst of 0
        mode = 1; burst_len = 5;
        start = 1; tick();
        wait_idle(40);
        burst_len = 0;
        start = 1; tick();
        wait_idle(40);
        mode = 0;

        // stop at ramp-up level 2
        start = 1; tick();
        tick();
        stop = 1; tick();
        wait_idle(20);

        // start and stop together in idle
        start = 1; stop = 1; tick();
        ticks(3);

        // ftw rewrite while running, plus an out-of-range index write
        start = 1; tick();
        ticks(8);
        cfg(0, 1, 40, 0, 0.3);
        cfg(3, 1, 77, 5, 0.9);
        ticks(10);
        stop = 1; tick();
        wait_idle(20);

        // reset in the middle of RUN
        start = 1; tick();
        ticks(8);
        rst_n = 0; tick();
        rst_n = 1; ticks(3);

        // wrap: ftw = all ones walks the phase backwards
        cfg(0, 1, 255, 10, 0.4);
        cfg(1, 1, 3, 200, 0.2);
        start = 1; tick();
        ticks(12);
        stop = 1; tick();
        wait_idle(20);

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_we    = 1;
                cfg_idx   = 2'($urandom_range(0, 3));
                cfg_en    = 1'($urandom_range(0, 1));
                cfg_ftw   = PW'($urandom);
                cfg_phase = PW'($urandom);
                cfg_amp   = real'($urandom_range(0, 1000)) / 2000.0;
            end
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 14) == 0);
            if (!busy) begin
                mode      = 1'($urandom_range(0, 1));
                burst_len = BW'($urandom_range(0, 6));
            end
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
            rst_n = 1;
        end
        stop = 1; tick();
        wait_idle(40);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
